// File: rtl/regfile_write_arbiter_pkg.sv
// Shared processor defines for the register-file write arbiter:
// arbiter state encoding, zero-register address and counter sizing.
package regfile_write_arbiter_pkg;

   // Arbiter states: buffer empty, buffer full and contending,
   // buffer full with the pipeline held.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FORCE = 2'd2
   } arb_state_t;

   // Architectural zero register: writes to it are discarded.
   localparam int ZERO_REG = 0;

   // Wait counter width; it covers starvation limits up to 7.
   localparam int CNT_W = 3;

endpackage

// File: rtl/io_write_buffer.sv
// Single-entry holding buffer for one IO register write (address + data).
module io_write_buffer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              ld,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   // Capture the IO write when the arbiter accepts it.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         // NOTE: the holding registers are cleared on reset so a discarded IO write leaves no stale data behind.
         addr <= '0;
         data <= '0;
      end else if (ld) begin
         // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of block ordering.
         addr <= ld_addr;
         data <= ld_data;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates register-file writes between the pipeline writeback and an
// IO peripheral. The pipeline normally wins; a buffered IO write that loses
// STARVE_LIMIT times in a row stalls the pipeline for one cycle to get in.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              io_valid,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_data,
   output logic              io_ready,
   output logic              stall,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
   localparam logic [CNT_W-1:0]  LIMIT     = CNT_W'(STARVE_LIMIT);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [CNT_W-1:0]  wait_cnt;
   logic [ADDR_W-1:0] buf_addr;
   logic [DATA_W-1:0] buf_data;

   logic wb_live;
   logic accept;
   logic grant_wb;
   logic grant_io;
   logic io_lost;
   logic limit_hit;

   // Pipeline writes to the zero register never count as real writes.
   assign wb_live   = wb_we && (wb_addr != ZERO_ADDR);
   // The buffer only accepts when empty, so it cannot reload on its grant edge.
   assign accept    = (state == ST_IDLE) && io_valid;
   assign grant_wb  = wb_live && (state != ST_FORCE);
   assign grant_io  = (state == ST_FORCE) || ((state == ST_WAIT) && !wb_live);
   assign io_lost   = (state == ST_WAIT) && wb_live;
   assign limit_hit = io_lost && ((wait_cnt + CNT_W'(1)) == LIMIT);

   io_write_buffer #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk     (clk),
      .clr     (clr),
      .ld      (accept),
      .ld_addr (io_addr),
      .ld_data (io_data),
      .addr    (buf_addr),
      .data    (buf_data)
   );

   // State register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: accept into WAIT, leave WAIT on grant or starvation.
   always_comb begin
      // NOTE: assigning a default before the case keeps this always_comb free of inferred latches.
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!wb_live) begin
               state_nxt = ST_IDLE;
            end else if (limit_hit) begin
               state_nxt = ST_FORCE;
            end
         end
         ST_FORCE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Handshake outputs decoded from registered state only.
   always_comb begin
      io_ready = (state == ST_IDLE);
      stall    = (state == ST_FORCE);
   end

   // Count consecutive arbitrations lost by the buffered IO write.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wait_cnt <= '0;
      end else if (accept) begin
         wait_cnt <= '0;
      end else if (io_lost) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   // Registered register-file write port: one-cycle enable per granted write,
   // address/data hold when nothing is written (including zero-register IO writes).
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= 1'b0;
         if (grant_wb) begin
            rf_we    <= 1'b1;
            rf_waddr <= wb_addr;
            rf_wdata <= wb_data;
         end else if (grant_io && (buf_addr != ZERO_ADDR)) begin
            rf_we    <= 1'b1;
            rf_waddr <= buf_addr;
            rf_wdata <= buf_data;
         end
      end
   end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register address width.
REQ-003 Parameter STARVE_LIMIT, default 3, SHALL set the number of consecutive lost IO arbitrations that forces a pipeline stall (legal range 1..7).
REQ-004 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 clr  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 wb_we  in  1  SHALL be the pipeline writeback write request.
REQ-007 wb_addr  in  ADDR_W  SHALL be the pipeline writeback destination register.
REQ-008 wb_data  in  DATA_W  SHALL be the pipeline writeback data.
REQ-009 io_valid  in  1  SHALL be the IO peripheral write request valid.
REQ-010 io_addr  in  ADDR_W  SHALL be the IO destination register.
REQ-011 io_data  in  DATA_W  SHALL be the IO write data.
REQ-012 io_ready  out  1  SHALL be high when the IO holding buffer is empty.
REQ-013 stall  out  1  SHALL be high while the arbiter forces the pipeline to hold its writeback.
REQ-014 rf_we  out  1  SHALL be the registered register-file write enable.
REQ-015 rf_waddr  out  ADDR_W  SHALL be the registered register-file write address.
REQ-016 rf_wdata  out  DATA_W  SHALL be the registered register-file write data.

Function
REQ-017 The block SHALL have states IDLE (buffer empty), WAIT (buffer full, contending) and FORCE (buffer full, stall asserted).
REQ-018 io_ready SHALL equal (state==IDLE); stall SHALL equal (state==FORCE); both decoded from registered state only.
REQ-019 An IO transfer SHALL occur on a rising edge with io_valid && io_ready: io_addr/io_data captured into the buffer, IDLE->WAIT, wait counter cleared to 0.
REQ-020 A pipeline write is "live" when wb_we==1 and wb_addr!=0.
REQ-021 In IDLE or WAIT, a live pipeline write SHALL win: rf_we<=1, rf_waddr<=wb_addr, rf_wdata<=wb_data.
REQ-022 In WAIT with no live pipeline write, the buffered IO write SHALL win: rf_* loaded from the buffer, WAIT->IDLE.
REQ-023 In WAIT, each edge the IO write loses SHALL increment the wait counter; the loss that makes it equal STARVE_LIMIT SHALL transition WAIT->FORCE.
REQ-024 In FORCE, the next edge SHALL grant the buffered IO write regardless of wb_we, ignore the pipeline write (pipeline re-presents it after stall drops), and transition FORCE->IDLE.
REQ-025 With no winner on an edge, rf_we SHALL be 0; rf_waddr/rf_wdata SHALL hold their previous values.
REQ-026 Writes to address 0 (either source) SHALL never assert rf_we; a buffered IO write to address 0 SHALL be consumed (WAIT->IDLE) with rf_we=0.
REQ-027 Latency: a live pipeline write presented before edge N SHALL appear on rf_* after edge N; minimum IO latency SHALL be 2 edges from acceptance to rf_we.
REQ-028 rf_we SHALL be high for exactly one cycle per granted write; outputs are registered so the register file's falling-edge capture sees stable values half a cycle later.
REQ-029 The buffer SHALL not accept a new IO request on the same edge it is granted; io_ready rises the cycle after the grant.

Reset
REQ-030 While clr==1: state=IDLE, wait counter=0, buffer contents=0, rf_we=0, rf_waddr=0, rf_wdata=0, io_ready=1, stall=0.
REQ-031 clr asserted mid-operation SHALL discard any pending buffered IO write without writing it.

Structure
REQ-032 State encodings (IDLE=2'd0, WAIT=2'd1, FORCE=2'd2) and the zero-register address constant SHALL live in the shared processor defines file.
REQ-033 The IO holding buffer (addr+data registers with load enable and async clear) SHALL be a sub-module named io_write_buffer.

Verification
REQ-034 Pipeline only: wb_we=1, wb_addr=5, wb_data=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, stall=0.
REQ-035 IO uncontended: io_valid=1, io_addr=7, io_data=0x12, wb_we=0 -> io_ready low one cycle after accept, rf_we=1/rf_waddr=7/rf_wdata=0x12 one cycle later, io_ready high next.
REQ-036 Starvation: IO accepted to addr 9, wb_we=1 with addr 3 every cycle -> three pipeline writes, then stall=1 for one cycle, then rf_waddr=9 with rf_we=1, pipeline addr-3 write not performed that cycle.
REQ-037 Zero register: wb_addr=0 with wb_we=1 and IO buffered to addr 0 -> rf_we stays 0 throughout; buffer consumed, io_ready returns high.
REQ-038 Reset mid-WAIT: IO buffered to addr 4, clr pulsed -> rf_we=0, io_ready=1, stall=0 immediately; no write to addr 4 ever occurs.
